// File: rtl/wfg_mem_seq_pkg.sv
// Shared types and constants for the waveform-generator memory sequencer:
// FSM state encoding, default widths and the Q6.10 gain fraction.
package wfg_mem_seq_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int GAIN_W     = 16;
    localparam int GAIN_FRAC  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } seq_state_e;

endpackage

// File: rtl/wfg_mem_seq_gain.sv
// Unsigned Q6.10 sample scaler: multiply, drop the fraction bits and
// saturate to all-ones when the integer part no longer fits DATA_W.
module wfg_mem_seq_gain
    import wfg_mem_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] sample_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int PROD_W   = DATA_W + GAIN_W;
    localparam int SCALED_W = PROD_W - GAIN_FRAC;

    logic [PROD_W-1:0]   product;
    logic [SCALED_W-1:0] scaled;

    assign product  = {{GAIN_W{1'b0}}, sample_i} * {{DATA_W{1'b0}}, gain_i};
    assign scaled   = SCALED_W'(product >> GAIN_FRAC);

    // Any set bit above DATA_W means the scaled value overflowed the stream width.
    assign result_o = (|scaled[SCALED_W-1:DATA_W]) ? '1 : scaled[DATA_W-1:0];

endmodule

// File: rtl/wfg_mem_sequencer.sv
// Sync-driven SRAM sample sequencer feeding an AXI-stream sample port.
// Optional Q6.10 gain stage is compiled in with WFG_MEM_SEQ_GAIN_EN.
module wfg_mem_sequencer
    import wfg_mem_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ctrl_en_i,
    input  logic [ADDR_W-1:0] cfg_start_i,
    input  logic [ADDR_W-1:0] cfg_end_i,
    input  logic [7:0]        cfg_inc_i,
    input  logic [GAIN_W-1:0] cfg_gain_i,
    input  logic              sync_i,
    output logic              mem_csb_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              axis_tvalid_o,
    input  logic              axis_tready_i,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              wrap_o,
    output logic              ovf_o
);

    localparam int SUM_W = ADDR_W + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              wrap_q, wrap_d;
    logic              ovf_q, ovf_d;
    logic              enPrev_q;

    logic              enRise;
    logic [7:0]        incEff;
    logic [SUM_W-1:0]  nextSum;
    logic              wrapHit;
    logic [DATA_W-1:0] sampleIn;

`ifdef WFG_MEM_SEQ_GAIN_EN
    wfg_mem_seq_gain #(
        .DATA_W (DATA_W)
    ) u_gain (
        .sample_i (mem_dout_i),
        .gain_i   (cfg_gain_i),
        .result_o (sampleIn)
    );
`else
    logic unusedGain;
    assign unusedGain = ^cfg_gain_i;
    assign sampleIn   = mem_dout_i;
`endif

    assign enRise  = ctrl_en_i & ~enPrev_q;
    assign incEff  = (cfg_inc_i == 8'd0) ? 8'd1 : cfg_inc_i;
    assign nextSum = {1'b0, addr_q} + SUM_W'(incEff);
    // The extra sum bit makes a carry-out compare greater than any end address.
    assign wrapHit = nextSum > {1'b0, cfg_end_i};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            tdata_q  <= '0;
            wrap_q   <= 1'b0;
            ovf_q    <= 1'b0;
            enPrev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tdata_q  <= tdata_d;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
            enPrev_q <= ctrl_en_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tdata_d    = tdata_q;
        wrap_d     = 1'b0;
        ovf_d      = ovf_q;
        mem_csb_o  = 1'b1;
        mem_addr_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_i && sync_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_csb_o  = 1'b0;
                mem_addr_o = addr_q;
                state_d    = ST_WAIT;
                addr_d     = wrapHit ? cfg_start_i : nextSum[ADDR_W-1:0];
                wrap_d     = wrapHit;
            end
            ST_WAIT: begin
                tdata_d = sampleIn;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (axis_tready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sync_i && (state_q != ST_IDLE)) begin
            ovf_d = 1'b1;
        end

        // Disabling abandons the in-flight sample without touching address or data.
        if (!ctrl_en_i) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
            tdata_d = tdata_q;
            wrap_d  = 1'b0;
        end

        if (enRise) begin
            addr_d = cfg_start_i;
            ovf_d  = 1'b0;
        end
    end

    assign axis_tvalid_o = (state_q == ST_HOLD);
    assign axis_tdata_o  = tdata_q;
    assign wrap_o        = wrap_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_wfg_mem_sequencer.sv
// Directed scoreboard bench for wfg_mem_sequencer; the gain checks are
// compiled only when WFG_MEM_SEQ_GAIN_EN is defined.
module tb_wfg_mem_sequencer;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] cfgStart;
    logic [AW-1:0] cfgEnd;
    logic [7:0]    cfgInc;
    logic [15:0]   cfgGain;
    logic          sync;
    logic          memCsb;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDout;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          wrap;
    logic          ovf;

    logic [DW-1:0] memImg [512];

    int            total = 0;
    int            bad   = 0;
    int            expAddrQ[$];
    bit            expWrapQ[$];
    logic [DW-1:0] expDataQ[$];
    logic [DW-1:0] lastData;

    int a1[6] = '{0, 1, 2, 3, 0, 1};
    bit w1[6] = '{0, 0, 0, 1, 0, 0};
    int a2[4] = '{1, 3, 1, 3};
    bit w2[4] = '{0, 1, 0, 1};
    int a3[4] = '{0, 1, 2, 0};
    bit w3[4] = '{0, 0, 1, 0};

    wfg_mem_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .ctrl_en_i     (en),
        .cfg_start_i   (cfgStart),
        .cfg_end_i     (cfgEnd),
        .cfg_inc_i     (cfgInc),
        .cfg_gain_i    (cfgGain),
        .sync_i        (sync),
        .mem_csb_o     (memCsb),
        .mem_addr_o    (memAddr),
        .mem_dout_i    (memDout),
        .axis_tvalid_o (tvalid),
        .axis_tready_i (tready),
        .axis_tdata_o  (tdata),
        .wrap_o        (wrap),
        .ovf_o         (ovf)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM read port: data appears the cycle after the select.
    always @(posedge clk) begin
        if (memCsb === 1'b0) memDout <= memImg[memAddr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int a, input bit w, input logic [DW-1:0] d);
        expAddrQ.push_back(a);
        expWrapQ.push_back(w);
        expDataQ.push_back(d);
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
    endtask

    // Called one cycle after the sync was sampled; walks to the valid cycle.
    task automatic waitSample(input string tag);
        int            lat     = 1;
        int            csbCnt  = 0;
        int            wrapCnt = 0;
        logic [AW-1:0] seen    = '0;
        int            eA;
        bit            eW;
        logic [DW-1:0] eD;
        while (tvalid !== 1'b1 && lat < 8) begin
            if (memCsb === 1'b0) begin
                csbCnt++;
                seen = memAddr;
            end
            if (wrap === 1'b1) wrapCnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (memCsb === 1'b0) csbCnt++;
        if (wrap === 1'b1) wrapCnt++;
        eA = expAddrQ.pop_front();
        eW = expWrapQ.pop_front();
        eD = expDataQ.pop_front();
        checkOutput({tag, ".latency"}, 64'(lat), 64'(3));
        checkOutput({tag, ".csbCycles"}, 64'(csbCnt), 64'(1));
        checkOutput({tag, ".addr"}, 64'(seen), 64'(eA));
        checkOutput({tag, ".wrapPulses"}, 64'(wrapCnt), eW ? 64'(1) : 64'(0));
        checkOutput({tag, ".tdata"}, 64'(tdata), 64'(eD));
        lastData = eD;
    endtask

    task automatic completeXfer(input string tag);
        tready = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, ".tvalidDrop"}, 64'(tvalid), 64'(0));
    endtask

    task automatic enableCfg(input int s, input int e, input int inc);
        en = 1'b0;
        @(posedge clk); #1;
        cfgStart = AW'(s);
        cfgEnd   = AW'(e);
        cfgInc   = 8'(inc);
        en       = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) memImg[i] = 32'(i + 10);
        rst      = 1'b1;
        en       = 1'b0;
        sync     = 1'b0;
        tready   = 1'b1;
        cfgStart = '0;
        cfgEnd   = '0;
        cfgInc   = 8'd1;
        cfgGain  = 16'h0400;
        memDout  = '0;
        #2;
        checkOutput("reset.tvalid", 64'(tvalid), 64'(0));
        checkOutput("reset.csb", 64'(memCsb), 64'(1));
        checkOutput("reset.memAddr", 64'(memAddr), 64'(0));
        checkOutput("reset.tdata", 64'(tdata), 64'(0));
        checkOutput("reset.wrap", 64'(wrap), 64'(0));
        checkOutput("reset.ovf", 64'(ovf), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] sequential walk start=0 end=3 inc=1");
        enableCfg(0, 3, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(a1[i], w1[i], memImg[a1[i]]);
            waitSample("walk");
            completeXfer("walk");
        end
        checkOutput("walk.ovf", 64'(ovf), 64'(0));

        $display("[TB] stride 2 and zero increment");
        enableCfg(1, 4, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a2[i], w2[i], memImg[a2[i]]);
            waitSample("stride2");
            completeXfer("stride2");
        end
        enableCfg(0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a3[i], w3[i], memImg[a3[i]]);
            waitSample("inc0");
            completeXfer("inc0");
        end

        $display("[TB] start beyond end");
        enableCfg(7, 2, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(7, 1'b1, memImg[7]);
            waitSample("startGtEnd");
            completeXfer("startGtEnd");
        end

        $display("[TB] backpressure and dropped sync");
        enableCfg(0, 3, 1);
        tready = 1'b0;
        applyStimulus(0, 1'b0, memImg[0]);
        waitSample("bp");
        for (int i = 0; i < 5; i++) begin
            sync = (i == 1);
            @(posedge clk); #1;
            sync = 1'b0;
            checkOutput("bp.tvalidHeld", 64'(tvalid), 64'(1));
            checkOutput("bp.tdataStable", 64'(tdata), 64'(lastData));
        end
        checkOutput("bp.ovfSet", 64'(ovf), 64'(1));
        completeXfer("bp");
        applyStimulus(1, 1'b0, memImg[1]);
        waitSample("bpNext");
        completeXfer("bpNext");
        checkOutput("bp.ovfSticky", 64'(ovf), 64'(1));
        en = 1'b0;
        @(posedge clk); #1;
        checkOutput("bp.ovfWhileOff", 64'(ovf), 64'(1));
        en = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp.ovfCleared", 64'(ovf), 64'(0));

        $display("[TB] reset during WAIT");
        enableCfg(5, 10, 1);
        applyStimulus(5, 1'b0, memImg[5]);
        waitSample("rstPre");
        completeXfer("rstPre");
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rstMid.tvalid", 64'(tvalid), 64'(0));
        checkOutput("rstMid.tdata", 64'(tdata), 64'(0));
        checkOutput("rstMid.csb", 64'(memCsb), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("rstPost.tvalid", 64'(tvalid), 64'(0));
        end
        applyStimulus(5, 1'b0, memImg[5]);
        waitSample("rstRestart");
        completeXfer("rstRestart");

        $display("[TB] disable during HOLD");
        tready = 1'b0;
        applyStimulus(6, 1'b0, memImg[6]);
        waitSample("enDrop");
        en = 1'b0;
        @(posedge clk); #1;
        checkOutput("enDrop.tvalid", 64'(tvalid), 64'(0));
        en = 1'b1;
        @(posedge clk); #1;
        tready = 1'b1;
        applyStimulus(5, 1'b0, memImg[5]);
        waitSample("enRestart");
        completeXfer("enRestart");

`ifdef WFG_MEM_SEQ_GAIN_EN
        $display("[TB] gain stage");
        memImg[0] = 32'h0000_0400;
        memImg[1] = 32'hFFFF_FFFF;
        en = 1'b0;
        cfgGain = 16'h0200;
        enableCfg(0, 1, 1);
        applyStimulus(0, 1'b0, 32'h0000_0200);
        waitSample("gainHalf");
        completeXfer("gainHalf");
        en = 1'b0;
        cfgGain = 16'h0800;
        enableCfg(1, 1, 1);
        applyStimulus(1, 1'b1, 32'hFFFF_FFFF);
        waitSample("gainSat");
        completeXfer("gainSat");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wfg_mem_sequencer.md
WFG_MEM_SEQUENCER -- requirements
Module: wfg_mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the SRAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the sample width on the memory and stream sides.
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port ctrl_en_i, input, 1 bit: sequencer enable.
REQ-006 Port cfg_start_i, input, ADDR_W bits: first sample address.
REQ-007 Port cfg_end_i, input, ADDR_W bits: last permitted address (inclusive).
REQ-008 Port cfg_inc_i, input, 8 bits: address step; a value of 0 SHALL be treated as 1.
REQ-009 Port cfg_gain_i, input, 16 bits: unsigned Q6.10 gain; it is used only when the gain feature is compiled in.
REQ-010 Port sync_i, input, 1 bit: a single-cycle request for the next sample.
REQ-011 Port mem_csb_o, output, 1 bit: SRAM read-port chip select (active-low).
REQ-012 Port mem_addr_o, output, ADDR_W bits: SRAM read address.
REQ-013 Port mem_dout_i, input, DATA_W bits: SRAM read data, valid in the cycle after the select cycle.
REQ-014 Ports axis_tvalid_o (output, 1), axis_tready_i (input, 1) and axis_tdata_o (output, DATA_W) form the sample stream to the SPI driver.
REQ-015 Port wrap_o, output, 1 bit: single-cycle pulse when the address wraps.
REQ-016 Port ovf_o, output, 1 bit: sticky flag set when a sync is dropped.

Function
REQ-017 SHALL implement the states IDLE, FETCH, WAIT and HOLD.
REQ-018 IDLE: when ctrl_en_i=1 and sync_i=1, the next state SHALL be FETCH.
REQ-019 FETCH: mem_csb_o=0 and mem_addr_o=addr, decoded combinationally from the state; the next state SHALL be WAIT.
REQ-020 WAIT: mem_dout_i (after gain, if compiled in) SHALL be registered into axis_tdata_o; the next state SHALL be HOLD.
REQ-021 HOLD: axis_tvalid_o=1; when axis_tready_i=1, the next state SHALL be IDLE.
REQ-022 Latency: sync_i sampled at edge k SHALL produce axis_tvalid_o=1 from cycle k+3.
REQ-023 axis_tdata_o SHALL remain stable while axis_tvalid_o=1 and axis_tready_i=0.
REQ-024 Address update at the end of FETCH: next = addr + max(cfg_inc_i,1), computed ADDR_W+1 bits wide.
REQ-025 If next > cfg_end_i, or the sum carries out, addr SHALL reload cfg_start_i and wrap_o SHALL pulse for one cycle.
REQ-026 When ctrl_en_i rises from 0 to 1, addr SHALL load cfg_start_i.
REQ-027 A sync_i=1 in FETCH, WAIT or HOLD SHALL be dropped and SHALL set ovf_o.
REQ-028 ovf_o SHALL clear only on reset or on a rising edge of ctrl_en_i.
REQ-029 If ctrl_en_i=0 in any state, the next state SHALL be IDLE and axis_tvalid_o SHALL drop in the next cycle; the aborted sample is discarded.
REQ-030 If cfg_start_i > cfg_end_i, every fetch SHALL wrap, so only cfg_start_i is ever read.
REQ-031 Configuration inputs SHALL be sampled at the point of use; software changes them only while disabled.

Reset
REQ-032 On wb_rst_i=1, asynchronously: state IDLE, addr 0, axis_tdata_o 0, axis_tvalid_o 0, mem_csb_o 1, mem_addr_o 0, wrap_o 0, ovf_o 0.
REQ-033 A reset asserted mid-transfer SHALL abandon the transfer with no partial handshake after release.

Configuration
REQ-034 The macro WFG_MEM_SEQ_GAIN_EN SHALL control the gain feature.
REQ-035 With WFG_MEM_SEQ_GAIN_EN defined: tdata = (mem_dout_i × cfg_gain_i) >> 10, truncated to DATA_W and saturated to all-ones on overflow; latency unchanged.
REQ-036 Without WFG_MEM_SEQ_GAIN_EN: tdata = mem_dout_i; cfg_gain_i is ignored and no multiplier is synthesised.

Structure
REQ-037 Package wfg_mem_seq_pkg SHALL hold the state enum, the gain fraction constant GAIN_FRAC=10 and the default widths.
REQ-038 Sub-module wfg_mem_seq_gain SHALL hold the multiply/shift/saturate logic and SHALL be instantiated only under WFG_MEM_SEQ_GAIN_EN.

Verification
REQ-039 start=0, end=3, inc=1, mem[i]=i+10, six syncs, tready=1 -> tdata 10,11,12,13,10,11; wrap_o pulses after the fetch of address 3.
REQ-040 start=1, end=4, inc=2 -> addresses 1,3,1,3; inc=0 with start=0, end=2 -> addresses 0,1,2,0.
REQ-041 tready held 0 for 5 cycles in HOLD, with a sync in the 2nd cycle -> tdata constant, tvalid held, ovf_o=1; ovf_o stays 1 until ctrl_en_i toggles.
REQ-042 wb_rst_i pulsed during WAIT, and separately ctrl_en_i dropped during HOLD -> tvalid 0 within 1 cycle; the next sync after re-enable reads cfg_start_i.
REQ-043 With WFG_MEM_SEQ_GAIN_EN: sample 0x400 with gain 0x200 -> 0x200; sample 0xFFFFFFFF with gain 0x800 -> 0xFFFFFFFF (saturated).
REQ-044 Check sync-to-tvalid latency = 3 cycles and mem_csb_o low for exactly 1 cycle per sample.
